// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
// The one-hot helper returns a vector of width MAX_OUT, which callers narrow to their own width.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int MAX_OUT   = 64;
   localparam int MAX_IDX_W = 6;

   // An index that is out of range gives an all-zero vector, so an invalid select can never light a line.
   function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx, input int unsigned n);
      logic [MAX_OUT-1:0] v;
      v = {MAX_OUT{1'b0}};
      if ((idx < n) && (idx < 32'(MAX_OUT))) begin
         v[idx[MAX_IDX_W-1:0]] = 1'b1;
      end else begin
         v = {MAX_OUT{1'b0}};
      end
      return v;
   endfunction

endpackage

// File: rtl/scan_counter.sv
// Walking-index generator for scan mode: holds each index for SCAN_DWELL cycles and wraps at N_OUT-1.
// While run is high, idx is the index that the decoder should show at the next clock edge.
module scan_counter
   import decoder_pkg::*;
#(
   parameter int N_OUT      = 4,
   parameter int SCAN_DWELL = 1
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     run,
   output logic [$clog2(N_OUT)-1:0] idx
);

   localparam int IDX_W = $clog2(N_OUT);
   localparam int DW_W  = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;

   logic [IDX_W-1:0] r_idx;
   logic [DW_W-1:0]  r_dwell;

   // Dwell counter and wrapping index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= {IDX_W{1'b0}};
         r_dwell <= {DW_W{1'b0}};
      end else if (clr) begin
         r_idx   <= {IDX_W{1'b0}};
         r_dwell <= {DW_W{1'b0}};
      end else if (run) begin
         if (r_dwell == DW_W'(SCAN_DWELL - 1)) begin
            r_dwell <= {DW_W{1'b0}};
            if (r_idx == IDX_W'(N_OUT - 1)) begin
               r_idx <= {IDX_W{1'b0}};
            end else begin
               r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            end
         end else begin
            r_dwell <= r_dwell + {{(DW_W-1){1'b0}}, 1'b1};
         end
      end else begin
         r_idx   <= r_idx;
         r_dwell <= r_dwell;
      end
   end

   assign idx = r_idx;

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with enable, valid/ready input and autonomous scan mode.
// Every output bit comes from a flop, so chip-select lines never glitch.
module onehot_decoder_seq
   import decoder_pkg::*;
#(
   parameter int SEL_W      = 2,
   parameter int N_OUT      = 4,
   parameter int PULSE      = 0,
   parameter int SCAN_DWELL = 1
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] sel,
   output logic [N_OUT-1:0] out,
   output logic             out_valid,
   output logic             err
);

   localparam int IDX_W = $clog2(N_OUT);

   state_t           r_state;
   logic [N_OUT-1:0] r_out;
   logic             r_out_valid;
   logic             r_err;

   logic             w_scan_run;
   logic             w_scan_clr;
   logic             w_transfer;
   logic             w_sel_ok;
   logic [IDX_W-1:0] w_idx;

   assign w_scan_run = en & (mode == MODE_SCAN);
   assign w_scan_clr = ~w_scan_run;
   assign in_ready   = en & (mode == MODE_DIRECT) & ~rst;
   assign w_transfer = in_valid & in_ready;
   assign w_sel_ok   = (32'(sel) < 32'(N_OUT));

   scan_counter #(
      .N_OUT      (N_OUT),
      .SCAN_DWELL (SCAN_DWELL)
   ) u_scan_counter (
      .clk (clk),
      .rst (rst),
      .clr (w_scan_clr),
      .run (w_scan_run),
      .idx (w_idx)
   );

   // Decoder FSM with registered out/out_valid/err; priority is rst, en, scan, then transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_out       <= {N_OUT{1'b0}};
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else if (!en) begin
         r_state     <= IDLE;
         r_out       <= {N_OUT{1'b0}};
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else if (mode == MODE_SCAN) begin
         r_state     <= SCAN;
         r_out       <= N_OUT'(onehot(32'(w_idx), 32'(N_OUT)));
         r_out_valid <= 1'b1;
         r_err       <= 1'b0;
      end else if (w_transfer) begin
         if (w_sel_ok) begin
            r_out       <= N_OUT'(onehot(32'(sel), 32'(N_OUT)));
            r_out_valid <= 1'b1;
            r_err       <= 1'b0;
            r_state     <= (PULSE != 0) ? IDLE : HOLD;
         end else begin
            r_out       <= {N_OUT{1'b0}};
            r_out_valid <= 1'b0;
            r_err       <= 1'b1;
            r_state     <= IDLE;
         end
      end else begin
         r_err <= 1'b0;
         // IDLE also retires a single-cycle pulse; leaving SCAN drops the walking bit.
         case (r_state)
            HOLD: begin
               r_state     <= HOLD;
               r_out       <= r_out;
               r_out_valid <= r_out_valid;
            end
            IDLE, SCAN: begin
               r_state     <= IDLE;
               r_out       <= {N_OUT{1'b0}};
               r_out_valid <= 1'b0;
            end
            default: begin
               r_state     <= IDLE;
               r_out       <= {N_OUT{1'b0}};
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign err       = r_err;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench: three decoder configurations share one stimulus stream.
// A vector table covers direct decode, enable override and scan; hand sequences cover err, pulse and async reset.
module tb_onehot_decoder_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       mode = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] sel = 2'd0;

   logic       a_ready, b_ready, c_ready;
   logic [3:0] a_out, c_out;
   logic [2:0] b_out;
   logic       a_valid, b_valid, c_valid;
   logic       a_err, b_err, c_err;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   onehot_decoder_seq #(.SEL_W(2), .N_OUT(4), .PULSE(0), .SCAN_DWELL(2)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(a_ready),
      .sel(sel), .out(a_out), .out_valid(a_valid), .err(a_err));

   onehot_decoder_seq #(.SEL_W(2), .N_OUT(3), .PULSE(0), .SCAN_DWELL(1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(b_ready),
      .sel(sel), .out(b_out), .out_valid(b_valid), .err(b_err));

   onehot_decoder_seq #(.SEL_W(2), .N_OUT(4), .PULSE(1), .SCAN_DWELL(1)) dut_c (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(c_ready),
      .sel(sel), .out(c_out), .out_valid(c_valid), .err(c_err));

   typedef struct {
      logic       e;
      logic       m;
      logic       v;
      logic [1:0] s;
      logic [3:0] o;
      logic       ov;
      logic       rdy;
   } vec_t;

   vec_t tbl [22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic e, input logic m, input logic v, input logic [1:0] s);
      en       = e;
      mode     = m;
      in_valid = v;
      sel      = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // en m  v  sel  out      ov    ready-before-edge
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0001, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0001, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0100, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0100, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b1000, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b1000, 1'b1, 1'b0};
      tbl[15] = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0001, 1'b1, 1'b0};
      tbl[16] = '{1'b1, 1'b1, 1'b1, 2'd1, 4'b0001, 1'b1, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1};
      tbl[18] = '{1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
      tbl[19] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1};
      tbl[20] = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1};
      tbl[21] = '{1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};

      // Reset is raised before any clock edge, so the values below can only come from the async path.
      #1 rst = 1'b1;
      #1;
      check("reset_out", 32'(a_out), 32'h0);
      check("reset_valid", 32'(a_valid), 32'h0);
      check("reset_err", 32'(a_err), 32'h0);
      check("reset_ready", 32'(a_ready), 32'h0);
      tick();
      tick();
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].e, tbl[i].m, tbl[i].v, tbl[i].s);
         #1;
         check($sformatf("vec%0d_ready", i), 32'(a_ready), 32'(tbl[i].rdy));
         tick();
         check($sformatf("vec%0d_out", i), 32'(a_out), 32'(tbl[i].o));
         check($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(tbl[i].ov));
         check($sformatf("vec%0d_err", i), 32'(a_err), 32'h0);
      end

      // N_OUT=3: the boundary select is decoded, one past it raises err.
      drive(1'b1, 1'b0, 1'b1, 2'd1); tick();
      check("b_sel1_out", 32'(b_out), 32'h2);
      check("b_sel1_valid", 32'(b_valid), 32'h1);
      drive(1'b1, 1'b0, 1'b1, 2'd2); tick();
      check("b_sel2_out", 32'(b_out), 32'h4);
      check("b_sel2_err", 32'(b_err), 32'h0);
      drive(1'b1, 1'b0, 1'b1, 2'd3); tick();
      check("b_sel3_out", 32'(b_out), 32'h0);
      check("b_sel3_valid", 32'(b_valid), 32'h0);
      check("b_sel3_err", 32'(b_err), 32'h1);
      drive(1'b1, 1'b0, 1'b0, 2'd0); tick();
      check("b_err_drop", 32'(b_err), 32'h0);
      check("b_idle_out", 32'(b_out), 32'h0);
      tick();
      check("b_idle_err", 32'(b_err), 32'h0);
      check("b_idle_valid", 32'(b_valid), 32'h0);

      // PULSE=1: a single pulse, then back-to-back pulses.
      drive(1'b1, 1'b0, 1'b1, 2'd1); tick();
      check("c_pulse_out", 32'(c_out), 32'h2);
      check("c_pulse_valid", 32'(c_valid), 32'h1);
      drive(1'b1, 1'b0, 1'b0, 2'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("c_after%0d_out", k), 32'(c_out), 32'h0);
         check($sformatf("c_after%0d_valid", k), 32'(c_valid), 32'h0);
      end
      drive(1'b1, 1'b0, 1'b1, 2'd1); tick();
      check("c_b2b0_out", 32'(c_out), 32'h2);
      drive(1'b1, 1'b0, 1'b1, 2'd3); tick();
      check("c_b2b1_out", 32'(c_out), 32'h8);
      check("c_b2b1_valid", 32'(c_valid), 32'h1);
      drive(1'b1, 1'b0, 1'b0, 2'd0); tick();
      check("c_b2b_end_out", 32'(c_out), 32'h0);

      // Async reset must clear a pending err pulse without a clock edge.
      drive(1'b1, 1'b0, 1'b1, 2'd3); tick();
      check("b_err_pre_rst", 32'(b_err), 32'h1);
      rst = 1'b1;
      #1;
      check("b_err_async_clr", 32'(b_err), 32'h0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 2'd0);
      rst = 1'b0;

      // Async reset mid-scan, then restart at index 0.
      tick();
      check("scan_pre0", 32'(a_out), 32'h1);
      tick();
      check("scan_pre1", 32'(a_out), 32'h1);
      tick();
      check("scan_pre2", 32'(a_out), 32'h2);
      check("c_scan_pre2", 32'(c_out), 32'h4);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_out", 32'(a_out), 32'h0);
      check("rst_mid_valid", 32'(a_valid), 32'h0);
      check("rst_mid_err", 32'(a_err), 32'h0);
      check("rst_mid_ready", 32'(a_ready), 32'h0);
      check("rst_mid_c_out", 32'(c_out), 32'h0);
      tick();
      check("rst_hold_out", 32'(a_out), 32'h0);
      rst = 1'b0;
      tick();
      check("scan_rs0", 32'(a_out), 32'h1);
      check("c_scan_rs0", 32'(c_out), 32'h1);
      tick();
      check("scan_rs1", 32'(a_out), 32'h1);
      check("c_scan_rs1", 32'(c_out), 32'h2);
      tick();
      check("scan_rs2", 32'(a_out), 32'h2);
      check("scan_rs2_valid", 32'(a_valid), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
